// File: rtl/debug_scan_master_pkg.sv
// debug_scan_master_pkg: scan states and default register widths shared with the debug slave.
package debug_scan_master_pkg;
  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI} scan_state_t;
endpackage

// File: rtl/debug_scan_tckgen.sv
// debug_scan_tckgen: tck phase counter; rise marks the first tck-high cycle, fall the last cycle of a period.
module debug_scan_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int PW = $clog2(2 * TCK_DIV);
  localparam logic [PW-1:0] HALF = PW'(TCK_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * TCK_DIV - 1);
  logic [PW-1:0] phase;
  always_ff @(posedge clk) begin
    if (reset) phase <= '0;
    else phase <= (run && phase != LAST) ? phase + 1'b1 : '0;
  end
  always_comb begin
    tck  = run && phase >= HALF;
    rise = run && phase == HALF;
    fall = run && phase == LAST;
  end
endmodule

// File: rtl/debug_scan_master.sv
// debug_scan_master: virtual-JTAG scan sequencer (UIR, CDR, SDR, UDR, RTI) driving a debug slave.
module debug_scan_master
  import debug_scan_master_pkg::*;
#(
  parameter int DR_WIDTH    = DR_WIDTH_DEF,
  parameter int IR_WIDTH    = IR_WIDTH_DEF,
  parameter int TCK_DIV     = 2,
  parameter int RTI_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IR_WIDTH-1:0] req_ir,
  input  logic [DR_WIDTH-1:0] req_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int BW = $clog2((DR_WIDTH > RTI_PERIODS ? DR_WIDTH : RTI_PERIODS) + 1);
  localparam logic [BW-1:0] SDR_LAST = BW'(DR_WIDTH - 1);
  localparam logic [BW-1:0] RTI_LAST = BW'(RTI_PERIODS - 1);
  scan_state_t state, state_nxt;
  logic [BW-1:0] bit_cnt;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] tdi_sh, tdo_sh;
  logic rise, fall, last_period, done;
  debug_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk  (clk),
    .reset(reset),
    .run  (state != IDLE),
    .tck  (vji_tck),
    .rise (rise),
    .fall (fall)
  );
  always_comb begin
    last_period = state == SDR ? bit_cnt == SDR_LAST : state == RTI ? bit_cnt == RTI_LAST : 1'b1;
    state_nxt   = state == IDLE ? (req_valid ? UIR : IDLE) :
                  (fall && last_period) ? (state == RTI ? IDLE : scan_state_t'(state + 3'd1)) : state;
    done        = state == RTI && state_nxt == IDLE;
    req_ready   = state == IDLE;
    vji_uir     = state == UIR;
    vji_cdr     = state == CDR;
    vji_sdr     = state == SDR;
    vji_udr     = state == UDR;
    vji_rti     = state == RTI;
    vji_ir_in   = state == IDLE ? '0 : ir_q;
    vji_tdi     = state == SDR && tdi_sh[0];
  end
  // tdi shifts at period end so each new bit is stable across the whole following period
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ir_q      <= '0;
      tdi_sh    <= '0;
      tdo_sh    <= '0;
      rsp_dr    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= done;
      if (done) rsp_dr <= tdo_sh;
      if (req_valid && req_ready) begin
        ir_q   <= req_ir;
        tdi_sh <= req_dr;
      end
      if (fall) bit_cnt <= state_nxt != state ? '0 : bit_cnt + 1'b1;
      if (state == SDR && fall) tdi_sh <= tdi_sh >> 1;
      if (state == SDR && rise) tdo_sh <= {vji_tdo, tdo_sh[DR_WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_debug_scan_master.sv
// tb_debug_scan_master: table-driven scan vectors plus reset, back-to-back and TCK_DIV=1 sequences.
module tb_debug_scan_master;
  localparam int DRW = 38;
  localparam int IRW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, rsp_valid;
  logic [IRW-1:0] req_ir = '0, ir_in;
  logic [DRW-1:0] req_dr = '0, rsp_dr;
  logic tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  int tdo_mode = 0;
  assign tdo = tdo_mode == 0 ? tdi : tdo_mode == 1;
  logic req_valid1 = 1'b0, req_ready1, rsp_valid1;
  logic [IRW-1:0] req_ir1 = '0, ir_in1;
  logic [DRW-1:0] req_dr1 = '0, rsp_dr1;
  logic tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  assign tdo1 = tdi1;
  debug_scan_master u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir),
    .req_dr(req_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .vji_tck(tck), .vji_tdi(tdi),
    .vji_tdo(tdo), .vji_ir_in(ir_in), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr),
    .vji_udr(udr), .vji_rti(rti)
  );
  debug_scan_master #(.TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1), .req_ir(req_ir1),
    .req_dr(req_dr1), .rsp_valid(rsp_valid1), .rsp_dr(rsp_dr1), .vji_tck(tck1), .vji_tdi(tdi1),
    .vji_tdo(tdo1), .vji_ir_in(ir_in1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
    .vji_udr(udr1), .vji_rti(rti1)
  );
  typedef struct {
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    int             mode;
    logic [DRW-1:0] exp;
  } vec_t;
  vec_t tbl[5];
  int errors = 0, checks = 0;
  int fcnt[5];
  int onehot_err, order_err, sdr_rises, ir_err, last_idx;
  logic prev_tck;
  logic [IRW-1:0] exp_ir;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clr_sb(input logic [IRW-1:0] ir);
    for (int i = 0; i < 5; i++) fcnt[i] = 0;
    onehot_err = 0; order_err = 0; sdr_rises = 0; ir_err = 0; last_idx = -1;
    prev_tck = 1'b0; exp_ir = ir;
  endtask
  task automatic sample();
    logic [4:0] f;
    int idx;
    f = {uir, cdr, sdr, udr, rti};
    idx = 0;
    if ($countones(f) != 1) onehot_err++;
    else begin
      for (int i = 0; i < 5; i++) if (f[4-i]) idx = i;
      if (idx != last_idx && idx != last_idx + 1) order_err++;
      last_idx = idx;
      fcnt[idx]++;
    end
    if (sdr && tck && !prev_tck) sdr_rises++;
    prev_tck = tck;
    if (ir_in !== exp_ir) ir_err++;
  endtask
  task automatic start(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_ir = ir; req_dr = dr; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  // latency = posedges after the accept edge up to and including the edge that samples rsp_valid
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      if (rsp_valid) break;
      sample();
      @(posedge clk);
      lat++;
    end
    lat = lat + 1;
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    tdo_mode = v.mode;
    start(v.ir, v.dr);
    clr_sb(v.ir);
    wait_rsp(lat);
    chk({tag, "_latency"}, lat, 181);
    chk({tag, "_rsp_dr"}, rsp_dr, v.exp);
    chk({tag, "_uir_cycles"}, fcnt[0], 4);
    chk({tag, "_cdr_cycles"}, fcnt[1], 4);
    chk({tag, "_sdr_cycles"}, fcnt[2], 152);
    chk({tag, "_udr_cycles"}, fcnt[3], 4);
    chk({tag, "_rti_cycles"}, fcnt[4], 16);
    chk({tag, "_onehot_err"}, onehot_err, 0);
    chk({tag, "_order_err"}, order_err, 0);
    chk({tag, "_sdr_tck_rises"}, sdr_rises, 38);
    chk({tag, "_ir_in_err"}, ir_err, 0);
    chk({tag, "_idle_ir_in"}, ir_in, 0);
    @(negedge clk);
    chk({tag, "_rsp_pulse_width"}, rsp_valid, 0);
    chk({tag, "_rsp_dr_hold"}, rsp_dr, v.exp);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, bad, w;
    tbl[0] = '{2'b01, 38'h2A_DEAD_BEEF, 0, 38'h2A_DEAD_BEEF};
    tbl[1] = '{2'b10, 38'h12_3456_789A, 1, 38'h3F_FFFF_FFFF};
    tbl[2] = '{2'b11, 38'h3F_FFFF_FFFF, 2, 38'h00_0000_0000};
    tbl[3] = '{2'b10, 38'h15_5555_5555, 0, 38'h15_5555_5555};
    tbl[4] = '{2'b11, 38'h20_0000_0001, 0, 38'h20_0000_0001};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_tck", tck, 0);
    chk("rst_flags", {uir, cdr, sdr, udr, rti}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dr", rsp_dr, 0);
    chk("rst_ir_in", ir_in, 0);
    chk("rst_tdi", tdi, 0);
    chk("rst_ready_div1", req_ready1, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid || tck || !req_ready || {uir, cdr, sdr, udr, rti} != 0) bad++;
    end
    chk("idle_100_cycles_bad", bad, 0);
    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    // back-to-back: second request waits with valid high and is taken on the rsp_valid cycle
    tdo_mode = 0;
    @(negedge clk);
    req_ir = 2'b10; req_dr = 38'h01_2345_6789; req_valid = 1'b1;
    @(posedge clk);
    #1 req_ir = 2'b01; req_dr = 38'h3E_CAFE_F00D;
    clr_sb(2'b10);
    wait_rsp(lat);
    chk("b2b_first_latency", lat, 181);
    chk("b2b_ready_on_rsp", req_ready, 1);
    chk("b2b_first_rsp_dr", rsp_dr, 38'h01_2345_6789);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("b2b_second_in_uir", {uir, req_ready, rsp_valid}, 3'b100);
    chk("b2b_second_ir_in", ir_in, 2'b01);
    chk("b2b_rsp_dr_held", rsp_dr, 38'h01_2345_6789);
    clr_sb(2'b01);
    wait_rsp(lat);
    chk("b2b_second_latency", lat, 181);
    chk("b2b_second_rsp_dr", rsp_dr, 38'h3E_CAFE_F00D);
    chk("b2b_second_sdr_cycles", fcnt[2], 152);
    // reset in the middle of SDR, at the start of bit 10
    start(2'b11, 38'h00_0000_0400);
    w = 0;
    while (!sdr && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_sdr_reached", sdr, 1);
    repeat (40) @(negedge clk);
    chk("mid_sdr_bit10_tdi", {sdr, tdi}, 2'b11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_dr", rsp_dr, 0);
    chk("mid_rst_tck_tdi", {tck, tdi}, 0);
    chk("mid_rst_ir_in", ir_in, 0);
    chk("mid_rst_flags", {uir, cdr, sdr, udr, rti}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid || tck) bad++;
    end
    chk("mid_rst_no_rsp", bad, 0);
    run_vec(tbl[0], "post_rst");
    // TCK_DIV=1 instance: loopback latency shrinks to 91
    @(negedge clk);
    req_ir1 = 2'b01; req_dr1 = 38'h2A_DEAD_BEEF; req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    lat = 0;
    while (lat < 1000) begin
      @(negedge clk);
      if (rsp_valid1) break;
      @(posedge clk);
      lat++;
    end
    chk("div1_latency", lat + 1, 91);
    chk("div1_rsp_dr", rsp_dr1, 38'h2A_DEAD_BEEF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
